// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Arbitrates one single-port unified memory between instruction
//               fetch (read-only) and MEM-stage data access (read/write) using
//               a fixed-latency IDLE/ACCESS/RESP FSM with data-over-fetch
//               priority. Optional macro ARB_FAIR_EN adds a streak limit that
//               lets fetch win after MAX_STREAK back-to-back contested data wins.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int             CNT_W      = 4;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LAT - 1);

    state_t              r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_cnt_q, w_cnt_d;
    logic                r_owner_q, w_owner_d;   // 1 = data, 0 = fetch
    logic                r_we_q, w_we_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
    logic [31:0]         r_wdata_q, w_wdata_d;
    logic [31:0]         r_if_rdata_q, w_if_rdata_d;
    logic [31:0]         r_dm_rdata_q, w_dm_rdata_d;

    logic                w_idle;
    logic                w_if_gnt;
    logic                w_dm_gnt;

    // Only word-address bits reach the memory; the rest are intentionally dropped.
    logic                w_unused_addr_bits;
    assign w_unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                  dm_addr[1:0], dm_addr[31:ADDR_W+2]};

    assign w_idle = (r_state_q == S_IDLE) && !rst;

`ifdef ARB_FAIR_EN
    localparam int                STREAK_W     = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak_q, w_streak_d;
    logic                w_fair_pick;

    assign w_fair_pick = (r_streak_q == c_streak_max) && if_req && dm_req;
    assign w_if_gnt    = w_idle && if_req && (!dm_req || w_fair_pick);
    assign w_dm_gnt    = w_idle && dm_req && !w_fair_pick;

    always_comb begin
        w_streak_d = r_streak_q;
        if (w_if_gnt) begin
            w_streak_d = '0;
        end else if (w_dm_gnt) begin
            w_streak_d = if_req ? (r_streak_q + 1'b1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak_q <= '0;
        end else begin
            r_streak_q <= w_streak_d;
        end
    end
`else
    localparam int c_unused_max_streak = MAX_STREAK;

    assign w_if_gnt = w_idle && if_req && !dm_req;
    assign w_dm_gnt = w_idle && dm_req;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_owner_d    = r_owner_q;
        w_we_d       = r_we_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_if_rdata_d = r_if_rdata_q;
        w_dm_rdata_d = r_dm_rdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_dm_gnt) begin
                    w_owner_d = 1'b1;
                    w_we_d    = dm_we;
                    w_addr_d  = dm_addr[ADDR_W+1:2];
                    w_wdata_d = dm_wdata;
                    w_cnt_d   = c_cnt_load;
                    w_state_d = S_ACCESS;
                end else if (w_if_gnt) begin
                    w_owner_d = 1'b0;
                    w_we_d    = 1'b0;
                    w_addr_d  = if_addr[ADDR_W+1:2];
                    w_wdata_d = '0;
                    w_cnt_d   = c_cnt_load;
                    w_state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt_q == '0) begin
                    // Read data is only guaranteed valid on the final access cycle.
                    if (!r_owner_q) begin
                        w_if_rdata_d = mem_rdata;
                    end else if (!r_we_q) begin
                        w_dm_rdata_d = mem_rdata;
                    end
                    w_state_d = S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_cnt_q      <= '0;
            r_owner_q    <= 1'b0;
            r_we_q       <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_if_rdata_q <= '0;
            r_dm_rdata_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_owner_q    <= w_owner_d;
            r_we_q       <= w_we_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_if_rdata_q <= w_if_rdata_d;
            r_dm_rdata_q <= w_dm_rdata_d;
        end
    end

    // Write strobe only on the last access cycle so an aborted store never writes.
    assign mem_en    = (r_state_q == S_ACCESS);
    assign mem_we    = mem_en && r_we_q && (r_cnt_q == '0);
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign if_rvalid = (r_state_q == S_RESP) && !r_owner_q;
    assign dm_rvalid = (r_state_q == S_RESP) && r_owner_q;
    assign if_rdata  = r_if_rdata_q;
    assign dm_rdata  = r_dm_rdata_q;
    assign busy      = (r_state_q != S_IDLE);

endmodule
`default_nettype wire
